// File: rtl/pipelined_cla_adder.sv
// Pipelined block carry-lookahead adder/subtractor with elastic valid/ready flow control.
// Segment j of the operands is resolved in stage j using the carry registered by stage j-1.
module pipelined_cla_adder #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int SEG = WIDTH / STAGES;
    localparam int GRP = SEG / BLOCK;

    // Returns {carry into segment MSB, segment carry-out, segment sum}.
    function automatic logic [SEG+1:0] seg_add(input logic [SEG-1:0] x, input logic [SEG-1:0] y,
                                               input logic c);
        logic [SEG-1:0] g, p, s;
        logic cg, gg, gp, cb, cm;
        int idx;
        g  = x & y;
        p  = x ^ y;
        s  = {SEG{1'b0}};
        cg = c;
        cm = 1'b0;
        for (int k = 0; k < GRP; k++) begin
            gg = 1'b0;
            gp = 1'b1;
            cb = cg;
            for (int t = 0; t < BLOCK; t++) begin
                idx    = k * BLOCK + t;
                s[idx] = p[idx] ^ cb;
                cm     = (idx == SEG - 1) ? cb : cm;
                cb     = g[idx] | (p[idx] & cb);
                gg     = g[idx] | (p[idx] & gg);
                gp     = gp & p[idx];
            end
            cg = gg | (gp & cg);
        end
        return {cm, cg, s};
    endfunction

    logic [STAGES-1:0] vld_q, vld_d, rdy_s, vin_s;
    logic [STAGES-1:0] car_q, car_d, cmsb_q, cmsb_d, cin_s;
    logic [WIDTH-1:0]  opa_q [STAGES];
    logic [WIDTH-1:0]  opa_d [STAGES];
    logic [WIDTH-1:0]  opb_q [STAGES];
    logic [WIDTH-1:0]  opb_d [STAGES];
    logic [WIDTH-1:0]  psum_q[STAGES];
    logic [WIDTH-1:0]  psum_d[STAGES];
    logic [WIDTH-1:0]  opa_s [STAGES];
    logic [WIDTH-1:0]  opb_s [STAGES];
    logic [WIDTH-1:0]  psum_s[STAGES];
    logic [SEG+1:0]    res_s;
    logic              dn_s;

    // A stage can load when it is empty or everything downstream of it is moving.
    always_comb begin
        rdy_s = {STAGES{1'b0}};
        dn_s  = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            dn_s     = ~vld_q[i] | dn_s;
            rdy_s[i] = dn_s;
        end
    end

    // Stage inputs, per-segment lookahead add, and hold-unless-advancing next state.
    always_comb begin
        opa_s[0]  = a;
        opb_s[0]  = b ^ {WIDTH{sub}};
        cin_s[0]  = cin ^ sub;
        psum_s[0] = {WIDTH{1'b0}};
        vin_s[0]  = in_valid;
        for (int i = 1; i < STAGES; i++) begin
            opa_s[i]  = opa_q[i-1];
            opb_s[i]  = opb_q[i-1];
            cin_s[i]  = car_q[i-1];
            psum_s[i] = psum_q[i-1];
            vin_s[i]  = vld_q[i-1];
        end
        res_s = {(SEG+2){1'b0}};
        for (int i = 0; i < STAGES; i++) begin
            res_s    = seg_add(opa_s[i][i*SEG +: SEG], opb_s[i][i*SEG +: SEG], cin_s[i]);
            vld_d[i] = rdy_s[i] ? vin_s[i] : vld_q[i];
            if (rdy_s[i] & vin_s[i]) begin
                opa_d[i]                 = opa_s[i];
                opb_d[i]                 = opb_s[i];
                psum_d[i]                = psum_s[i];
                psum_d[i][i*SEG +: SEG]  = res_s[SEG-1:0];
                car_d[i]                 = res_s[SEG];
                cmsb_d[i]                = res_s[SEG+1];
            end else begin
                opa_d[i]  = opa_q[i];
                opb_d[i]  = opb_q[i];
                psum_d[i] = psum_q[i];
                car_d[i]  = car_q[i];
                cmsb_d[i] = cmsb_q[i];
            end
        end
    end

    // Pipeline stage registers; reset discards every in-flight beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= {STAGES{1'b0}};
            car_q  <= {STAGES{1'b0}};
            cmsb_q <= {STAGES{1'b0}};
            opa_q  <= '{default: {WIDTH{1'b0}}};
            opb_q  <= '{default: {WIDTH{1'b0}}};
            psum_q <= '{default: {WIDTH{1'b0}}};
        end else begin
            vld_q  <= vld_d;
            car_q  <= car_d;
            cmsb_q <= cmsb_d;
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            psum_q <= psum_d;
        end
    end

    assign in_ready  = rdy_s[0];
    assign out_valid = vld_q[STAGES-1];
    assign sum       = psum_q[STAGES-1];
    assign cout      = car_q[STAGES-1];
    assign ovf       = car_q[STAGES-1] ^ cmsb_q[STAGES-1];
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench: arithmetic reference queue for the 32-bit/2-stage instance plus
// directed carry-chain checks on three other configurations.
module tb_pipelined_cla_adder;
    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        o;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [31:0] a, b, sum;

    logic        in_valid_x, cin_x, sub_x, out_ready_x;
    logic        ir8, ov8, co8, of8, ir64, ov64, co64, of64, ir16, ov16, co16, of16;
    logic [7:0]  a8, b8, s8;
    logic [63:0] a64, b64, s64;
    logic [15:0] a16, b16, s16;

    int checks = 0, failures = 0, cyc = 0;
    int last_pop = -10, run = 0, max_run = 0;
    exp_t q[$];
    logic hold_p = 1'b0;
    logic [63:0] held;

    pipelined_cla_adder #(.WIDTH(32), .BLOCK(4), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf));
    pipelined_cla_adder #(.WIDTH(8), .BLOCK(4), .STAGES(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_x), .in_ready(ir8), .a(a8), .b(b8),
        .cin(cin_x), .sub(sub_x), .out_valid(ov8), .out_ready(out_ready_x), .sum(s8),
        .cout(co8), .ovf(of8));
    pipelined_cla_adder #(.WIDTH(64), .BLOCK(8), .STAGES(4)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_x), .in_ready(ir64), .a(a64), .b(b64),
        .cin(cin_x), .sub(sub_x), .out_valid(ov64), .out_ready(out_ready_x), .sum(s64),
        .cout(co64), .ovf(of64));
    pipelined_cla_adder #(.WIDTH(16), .BLOCK(2), .STAGES(8)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_x), .in_ready(ir16), .a(a16), .b(b16),
        .cin(cin_x), .sub(sub_x), .out_valid(ov16), .out_ready(out_ready_x), .sum(s16),
        .cout(co16), .ovf(of16));

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", nm, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                   input logic c, input logic s);
        logic [31:0] bx;
        logic [32:0] full;
        exp_t e;
        bx   = s ? ~bv : bv;
        full = {1'b0, av} + {1'b0, bx} + {32'd0, c ^ s};
        e.s  = full[31:0];
        e.c  = full[32];
        e.o  = (av[31] == bx[31]) && (full[31] != av[31]);
        return e;
    endfunction

    // Compare process: hold stability, in-order results, and accepted-beat capture.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
            hold_p = 1'b0;
        end else begin
            if (hold_p) begin
                chk("hold_valid", {63'd0, out_valid}, 64'd1);
                chk("hold_data", {30'd0, cout, ovf, sum}, held);
            end
            hold_p = out_valid & ~out_ready;
            held   = {30'd0, cout, ovf, sum};
            if (out_valid & out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", {63'd0, out_valid}, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("model_result", {30'd0, cout, ovf, sum}, {30'd0, e.c, e.o, e.s});
                end
                run      = (last_pop == cyc - 1) ? run + 1 : 1;
                last_pop = cyc;
                if (run > max_run) max_run = run;
            end
            if (in_valid & in_ready) q.push_back(model(a, b, cin, sub));
        end
    end

    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic c, input logic s);
        int t;
        logic ok;
        a = av; b = bv; cin = c; sub = s; in_valid = 1'b1; t = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!ok && t < 50);
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", {63'd0, ok}, 64'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && (q.size() != 0 || out_valid); k++) @(negedge clk);
        chk("drain_empty", q.size(), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        logic g8, g64, g16;
        rst_n = 1'b0; in_valid = 1'b0; a = 32'd0; b = 32'd0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1; in_valid_x = 1'b0; cin_x = 1'b0; sub_x = 1'b0; out_ready_x = 1'b1;
        a8 = 8'd0; b8 = 8'd0; a64 = 64'd0; b64 = 64'd0; a16 = 16'd0; b16 = 16'd0;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_flags_sum", {30'd0, cout, ovf, sum}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Full-width carry ripple and exact two-cycle latency
        send(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        @(negedge clk);
        chk("t1_not_early", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk("t1_valid", {63'd0, out_valid}, 64'd1);
        chk("t1_result", {30'd0, cout, ovf, sum}, {30'd0, 1'b1, 1'b0, 32'h0000_0000});
        drain();
        send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("t2_ovf", {30'd0, cout, ovf, sum}, {30'd0, 1'b0, 1'b1, 32'h8000_0000});
        drain();
        send(32'd5, 32'd7, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        chk("t2_sub", {30'd0, cout, ovf, sum}, {30'd0, 1'b0, 1'b0, 32'hFFFF_FFFE});
        drain();

        // Back-to-back stream
        max_run = 0;
        for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom));
        drain();
        chk("t3_consecutive", max_run, 64'd8);

        // Backpressure: fill, then accept and consume together while full
        out_ready = 1'b0; in_valid = 1'b1; acc = 0;
        for (int i = 0; i < 5; i++) begin
            a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk);
            #1;
        end
        chk("t4_accepted_while_stalled", acc, 64'd2);
        chk("t4_in_ready_full", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            @(negedge clk);
            chk("t4_in_ready_flow", {63'd0, in_ready}, 64'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(32'd1, 32'd2, 1'b0, 1'b0);
        send(32'd3, 32'd4, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("t5_rst_sum", {32'd0, sum}, 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        chk("t5_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        send(32'd100, 32'd23, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("t5_first_beat", {30'd0, cout, ovf, sum}, {30'd0, 1'b0, 1'b0, 32'd124});
        drain();

        // Other configurations: full-length carry chain in each
        for (int r = 0; r < 2; r++) begin
            if (r == 0) begin
                a8 = 8'h55; b8 = 8'hAA; a64 = 64'h5555_5555_5555_5555; b64 = 64'hAAAA_AAAA_AAAA_AAAA;
                a16 = 16'h5555; b16 = 16'hAAAA; cin_x = 1'b1; sub_x = 1'b0;
            end else begin
                a8 = 8'h00; b8 = 8'h00; a64 = 64'd0; b64 = 64'd0;
                a16 = 16'h0000; b16 = 16'h0000; cin_x = 1'b0; sub_x = 1'b1;
            end
            in_valid_x = 1'b1; g8 = 1'b0; g64 = 1'b0; g16 = 1'b0;
            for (int c = 1; c <= 12; c++) begin
                @(posedge clk);
                #1 in_valid_x = 1'b0;
                @(negedge clk);
                if (ov8 && !g8) begin
                    g8 = 1'b1;
                    chk("t6_w8_latency", c, 64'd1);
                    chk("t6_w8_result", {54'd0, co8, of8, s8}, {54'd0, 1'b1, 1'b0, 8'h00});
                end
                if (ov64 && !g64) begin
                    g64 = 1'b1;
                    chk("t6_w64_latency", c, 64'd4);
                    chk("t6_w64_sum", s64, 64'd0);
                    chk("t6_w64_flags", {62'd0, co64, of64}, {62'd0, 1'b1, 1'b0});
                end
                if (ov16 && !g16) begin
                    g16 = 1'b1;
                    chk("t6_w16_latency", c, 64'd8);
                    chk("t6_w16_result", {46'd0, co16, of16, s16}, {46'd0, 1'b1, 1'b0, 16'h0000});
                end
            end
            chk("t6_all_seen", {61'd0, g8, g64, g16}, 64'd7);
            @(posedge clk);
            #1;
        end

        chk("final_queue_empty", q.size(), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
